mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter bit_size, default 15, data word is bit_size+1 bits wide.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, CPU access request present.
REQ-005 The block SHALL have port req_ready, output, 1, request accepted on the edge where req_valid & req_ready.
REQ-006 The block SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 The block SHALL have port req_addr, input, 12, word address 0x000-0xFFF.
REQ-008 The block SHALL have port req_wdata, input, bit_size+1, store data.
REQ-009 The block SHALL have port rsp_valid, output, 1, one-cycle pulse marking load data valid; no backpressure.
REQ-010 The block SHALL have port rsp_data, output, bit_size+1, load result.
REQ-011 The block SHALL have port sb_empty, output, 1, store buffer holds no entries.
REQ-012 The block SHALL have port mem_read, output, 1, drives data memory dataMemRead.
REQ-013 The block SHALL have port mem_write, output, 1, drives data memory dataMemWrite.
REQ-014 The block SHALL have port mem_addr, output, 12, drives data memory address.
REQ-015 The block SHALL have port mem_value, output, bit_size+1, drives data memory value.
REQ-016 The block SHALL have port mem_out, input, bit_size+1, data memory read output (combinational).

Function
REQ-017 The block SHALL contain a 4-entry FIFO store buffer of {addr, data} with head/tail pointers and a 0-4 count.
REQ-018 The FSM SHALL have states IDLE, LOAD, DRAIN.
REQ-019 req_ready SHALL be 1 only when state is IDLE and count < 4, for loads and stores alike.
REQ-020 An accepted store SHALL be enqueued at the accepting edge; state remains IDLE.
REQ-021 An accepted load SHALL compare req_addr against all valid buffer entries; on a hit, rsp_data SHALL load the youngest matching entry's data and rsp_valid SHALL be 1 in the next cycle; state remains IDLE.
REQ-022 An accepted load that misses SHALL latch req_addr and go to LOAD.
REQ-023 In LOAD, mem_read SHALL be 1 and mem_addr the latched address; rsp_data SHALL capture mem_out at the end of LOAD; the next state SHALL be IDLE with rsp_valid = 1 (response two cycles after the accepting edge).
REQ-024 In IDLE with no request accepted and count > 0, the next state SHALL be DRAIN.
REQ-025 In DRAIN, mem_write SHALL be 1 with mem_addr/mem_value from the head entry; head SHALL pop at the end of DRAIN; the next state SHALL be IDLE.
REQ-026 mem_read, mem_write, mem_addr and mem_value SHALL be decoded from registered state only, never from req_* inputs, and SHALL be stable for the whole cycle.
REQ-027 mem_read and mem_write SHALL never be 1 in the same cycle; outside LOAD/DRAIN, both SHALL be 0 and mem_addr/mem_value 0.
REQ-028 rsp_valid SHALL be 1 for exactly one cycle per accepted load; it SHALL be 0 otherwise.
REQ-029 Stores SHALL reach memory in acceptance order; pointers SHALL wrap modulo 4; address 0xFFF SHALL be handled like any other address.
REQ-030 sb_empty SHALL equal (count == 0).

Reset
REQ-031 With rst_n = 0 at an edge: state IDLE, count/head/tail 0, rsp_valid 0, rsp_data 0; mem_read = mem_write = 0 in the following cycle.
REQ-032 Reset during LOAD or DRAIN SHALL abort the operation: no rsp_valid, no pop; all buffered stores SHALL be discarded.

Verification
REQ-033 Store 0x0A5 <- 0x1234, then req_valid low -> DRAIN cycle with mem_write = 1, mem_addr = 0x0A5, mem_value = 0x1234; sb_empty = 1 afterwards.
REQ-034 Load 0x010 from zeroed memory, buffer empty -> mem_read = 1 for one cycle, then rsp_valid = 1 with rsp_data = 0x0000, two cycles after acceptance.
REQ-035 Back-to-back stores 0x020 <- 0x1111 and 0x020 <- 0x2222, then load 0x020 -> rsp_valid the next cycle with rsp_data = 0x2222; no mem_read.
REQ-036 Five consecutive stores with req_valid held -> four accepted, req_ready = 0 at count 4; DRAIN writes the first-accepted store, then the fifth is accepted.
REQ-037 rst_n low during the LOAD cycle -> no rsp_valid, mem_read = 0 in the next cycle, sb_empty = 1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: 4-entry store buffer with load forwarding in front of a
// single-port data memory. Loads that miss the buffer take one LOAD cycle.
module mem_access_unit #(
   parameter int unsigned bit_size = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [11:0]       req_addr,
   input  logic [bit_size:0] req_wdata,
   output logic              rsp_valid,
   output logic [bit_size:0] rsp_data,
   output logic              sb_empty,
   output logic              mem_read,
   output logic              mem_write,
   output logic [11:0]       mem_addr,
   output logic [bit_size:0] mem_value,
   input  logic [bit_size:0] mem_out
);

   typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

   state_e            state_q, state_d;
   logic [2:0]        count_q, count_d;
   logic [1:0]        head_q, head_d;
   logic [1:0]        tail_q, tail_d;
   logic [11:0]       load_addr_q, load_addr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [bit_size:0] rsp_data_q, rsp_data_d;
   logic [11:0]       sb_addr_q [4];
   logic [bit_size:0] sb_data_q [4];

   logic              accept;
   logic              push;
   logic              hit;
   logic [bit_size:0] hit_data;

   assign req_ready = (state_q == StIdle) && (count_q < 3'd4);
   assign accept    = req_valid & req_ready;
   assign push      = accept & req_write;
   assign sb_empty  = (count_q == 3'd0);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

   // Walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int k = 0; k < 4; k++) begin
         if ((3'(k) < count_q) && (sb_addr_q[head_q + 2'(k)] == req_addr)) begin
            hit      = 1'b1;
            hit_data = sb_data_q[head_q + 2'(k)];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      head_d      = head_q;
      tail_d      = tail_q;
      load_addr_d = load_addr_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_value   = '0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_write) begin
                  tail_d  = tail_q + 2'd1;
                  count_d = count_q + 3'd1;
               end else if (hit) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = hit_data;
               end else begin
                  load_addr_d = req_addr;
                  state_d     = StLoad;
               end
            end else if (count_q != 3'd0) begin
               state_d = StDrain;
            end
         end
         StLoad: begin
            mem_read    = 1'b1;
            mem_addr    = load_addr_q;
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_out;
            state_d     = StIdle;
         end
         StDrain: begin
            mem_write = 1'b1;
            mem_addr  = sb_addr_q[head_q];
            mem_value = sb_data_q[head_q];
            head_d    = head_q + 2'd1;
            count_d   = count_q - 3'd1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         count_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         load_addr_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         load_addr_q <= load_addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Entry storage needs no reset; validity is defined by head/count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         sb_addr_q[tail_q] <= req_addr;
         sb_data_q[tail_q] <= req_wdata;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expectations,
// a negedge monitor pops them whenever the DUT responds or touches memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [11:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        sb_empty;
   logic        mem_read;
   logic        mem_write;
   logic [11:0] mem_addr;
   logic [15:0] mem_value;
   logic [15:0] mem_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_unit #(.bit_size(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .sb_empty  (sb_empty),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_value (mem_value),
      .mem_out   (mem_out)
   );

   // Data memory: combinational read, write on the rising edge.
   logic [15:0] mem [0:4095] = '{default: '0};
   always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_value;
   assign mem_out = mem[mem_addr];

   typedef struct {logic [15:0] data; int cyc;} rsp_t;
   typedef struct {logic [11:0] addr; int cyc;} rd_t;
   typedef struct {logic [11:0] addr; logic [15:0] data;} wr_t;
   rsp_t rsp_q[$];
   rd_t  rd_q[$];
   wr_t  wr_q[$];
   rsp_t r;
   rd_t  rd;
   wr_t  wr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h, expected no event", name, act);
   endtask

   always @(negedge clk) begin
      check("mem_rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (!mem_read && !mem_write) check("mem_bus_idle_zero", 32'({mem_addr, mem_value}), 32'd0);
      if (rsp_valid) begin
         if (rsp_q.size() == 0) unexpected("unexpected_rsp", 32'(rsp_data));
         else begin
            r = rsp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(r.data));
            check("rsp_cycle", 32'(cyc), 32'(r.cyc));
         end
      end
      if (mem_read) begin
         if (rd_q.size() == 0) unexpected("unexpected_mem_read", 32'(mem_addr));
         else begin
            rd = rd_q.pop_front();
            check("mem_read_addr", 32'(mem_addr), 32'(rd.addr));
            check("mem_read_cycle", 32'(cyc), 32'(rd.cyc));
         end
      end
      if (mem_write) begin
         if (wr_q.size() == 0) unexpected("unexpected_mem_write", 32'(mem_addr));
         else begin
            wr = wr_q.pop_front();
            check("mem_write_addr", 32'(mem_addr), 32'(wr.addr));
            check("mem_write_value", 32'(mem_value), 32'(wr.data));
         end
      end
   end

   task automatic idle();
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   // lat: 0 store (expect write), 1 load hit, 2 load miss, -1 no write/response expected.
   task automatic issue(input logic w, input logic [11:0] a, input logic [15:0] d,
                        input int lat, input logic [15:0] exp_data, output int acc_cyc);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         unexpected("req_ready_timeout", 32'(a));
         acc_cyc = -1;
         return;
      end
      acc_cyc = cyc;
      if (w) begin
         if (lat >= 0) wr_q.push_back('{addr: a, data: d});
      end else begin
         if (lat != 1) rd_q.push_back('{addr: a, cyc: cyc + 1});
         if (lat > 0) rsp_q.push_back('{data: exp_data, cyc: cyc + lat});
      end
      @(negedge clk);
   endtask

   task automatic wait_drain();
      idle();
      for (int i = 0; i < 50 && !sb_empty; i++) @(negedge clk);
      check("drain_sb_empty", 32'(sb_empty), 32'd1);
      repeat (3) @(negedge clk);
      check("write_queue_drained", 32'(wr_q.size()), 32'd0);
      check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int acc [5];
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", 32'(rsp_data), 32'd0);
      check("reset_mem_read", 32'(mem_read), 32'd0);
      check("reset_mem_write", 32'(mem_write), 32'd0);
      check("reset_sb_empty", 32'(sb_empty), 32'd1);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single store drains on the first idle cycle.
      issue(1'b1, 12'h0A5, 16'h1234, 0, 16'h0, c);
      wait_drain();
      check("mem_0a5_written", 32'(mem[12'h0A5]), 32'h1234);

      // Load miss from zeroed memory: response two cycles after acceptance.
      issue(1'b0, 12'h010, 16'h0, 2, 16'h0000, c);
      idle();
      repeat (3) @(negedge clk);
      check("miss_rsp_seen", 32'(rsp_q.size()), 32'd0);
      check("miss_read_seen", 32'(rd_q.size()), 32'd0);

      // Youngest matching store forwards; no memory read.
      issue(1'b1, 12'h020, 16'h1111, 0, 16'h0, c);
      issue(1'b1, 12'h020, 16'h2222, 0, 16'h0, c);
      issue(1'b0, 12'h020, 16'h0, 1, 16'h2222, c);
      wait_drain();

      // Earlier drained store read back through memory.
      issue(1'b0, 12'h0A5, 16'h0, 2, 16'h1234, c);
      idle();
      repeat (3) @(negedge clk);

      // Top address: forward, drain, then read back from memory.
      issue(1'b1, 12'hFFF, 16'hBEEF, 0, 16'h0, c);
      issue(1'b0, 12'hFFF, 16'h0, 1, 16'hBEEF, c);
      wait_drain();
      issue(1'b0, 12'hFFF, 16'h0, 2, 16'hBEEF, c);
      idle();
      repeat (3) @(negedge clk);

      // Five held stores: fill to four, one drain, then the fifth wraps into slot 0.
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, 12'(12'h100 + i), 16'(16'hA000 + i), 0, 16'h0, acc[i]);
         if (i == 3) begin
            check("full_req_ready_low", 32'(req_ready), 32'd0);
            check("full_sb_not_empty", 32'(sb_empty), 32'd0);
         end
      end
      check("fifth_accept_delay", 32'(acc[4] - acc[3]), 32'd3);
      wait_drain();

      // Reset during LOAD with a buffered store: everything is dropped.
      issue(1'b1, 12'h040, 16'h5555, -1, 16'h0, c);
      issue(1'b0, 12'h030, 16'h0, -1, 16'h0, c);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_mem_read", 32'(mem_read), 32'd0);
      check("abort_sb_empty", 32'(sb_empty), 32'd1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_no_write", 32'(mem[12'h040]), 32'd0);
      check("abort_read_queue", 32'(rd_q.size()), 32'd0);
      check("abort_write_queue", 32'(wr_q.size()), 32'd0);
      check("abort_rsp_queue", 32'(rsp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
